// File: rtl/multi_id_buffering.sv
// multi_id_buffering: two-beat request buffer that parks masked IDs in a FIFO drained only in device opmode.
// Defining MBUF_FILL_LEVEL_EN adds the registered fill_level_o occupancy port.
module multi_id_buffering #(
    parameter int DATA_W = 16,
    parameter int ID_W = 3,
    parameter int DEPTH = 8,
    parameter logic [2**ID_W-1:0] BUF_ID_MASK = 8'b0010_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_tvalid_i,
    input  logic [ID_W-1:0]        req_tid_i,
    input  logic [DATA_W-1:0]      req_tdata_i,
    output logic                   req_tready_o,
    output logic                   dev_valid_o,
    output logic [DATA_W+ID_W-1:0] dev_addr_o,
    output logic [DATA_W-1:0]      dev_data_o,
    input  logic                   dev_ready_i,
    input  logic                   dev_opmode_i
`ifdef MBUF_FILL_LEVEL_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] fill_level_o
`endif
);
    localparam int AW = DATA_W + ID_W;
    localparam int EW = AW + DATA_W;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [1:0] {IDLE, DATA, SEND, DRAIN} state_t;
    state_t state, state_n;
    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic [AW-1:0] hdr, out_addr;
    logic [DATA_W-1:0] out_data;
    logic full, empty, pop, push, hdr_buf;
    assign full = count == CW'(DEPTH);
    assign empty = count == '0;
    assign hdr_buf = BUF_ID_MASK[hdr[ID_W-1:0]];
    // Draining wins over a new address beat in IDLE
    assign pop = state == IDLE && dev_opmode_i && !empty;
    assign push = state == DATA && req_tvalid_i && hdr_buf;
    assign dev_valid_o = state == SEND || state == DRAIN;
    assign dev_addr_o = dev_valid_o ? out_addr : '0;
    assign dev_data_o = dev_valid_o ? out_data : '0;
`ifdef MBUF_FILL_LEVEL_EN
    assign fill_level_o = count;
`endif
    always_comb begin
        req_tready_o = 1'b0;
        state_n = state;
        case (state)
            IDLE: begin
                req_tready_o = !reset && !pop && !(BUF_ID_MASK[req_tid_i] && full);
                state_n = pop ? DRAIN : ((req_tvalid_i && req_tready_o) ? DATA : IDLE);
            end
            DATA: begin
                req_tready_o = !reset;
                state_n = req_tvalid_i ? (hdr_buf ? IDLE : SEND) : DATA;
            end
            default: state_n = dev_ready_i ? IDLE : state;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            hdr <= '0;
            out_addr <= '0;
            out_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && req_tvalid_i && req_tready_o) hdr <= {req_tdata_i, req_tid_i};
            if (state == DATA && req_tvalid_i && !hdr_buf) begin
                out_addr <= hdr;
                out_data <= req_tdata_i;
            end
            if (pop) begin
                {out_addr, out_data} <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            count <= push ? count + 1'b1 : (pop ? count - 1'b1 : count);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !reset) mem[wr_ptr] <= {hdr, req_tdata_i};
    end
endmodule

// File: tb/tb_multi_id_buffering.sv
// tb_multi_id_buffering: directed and randomized requests checked every cycle against a queue-based request model.
module tb_multi_id_buffering;
    localparam int DEPTH = 8;
    localparam logic [7:0] MASK = 8'b0010_0000;
    logic clk, reset, req_tvalid_i, req_tready_o, dev_valid_o, dev_ready_i, dev_opmode_i;
    logic [2:0] req_tid_i;
    logic [15:0] req_tdata_i, dev_data_o;
    logic [18:0] dev_addr_o;
`ifdef MBUF_FILL_LEVEL_EN
    logic [3:0] fill;
`endif
    int tests = 0, fails = 0;
    bit armed = 0, rnd = 0;
    logic [34:0] mq [$];
    bit half_v = 0, pres_v = 0;
    logic [15:0] half_a, pres_data;
    logic [2:0] half_id;
    logic [18:0] pres_addr;

    multi_id_buffering #(.DATA_W(16), .ID_W(3), .DEPTH(DEPTH), .BUF_ID_MASK(MASK)) dut (
        .clk(clk), .reset(reset), .req_tvalid_i(req_tvalid_i), .req_tid_i(req_tid_i),
        .req_tdata_i(req_tdata_i), .req_tready_o(req_tready_o), .dev_valid_o(dev_valid_o),
        .dev_addr_o(dev_addr_o), .dev_data_o(dev_data_o), .dev_ready_i(dev_ready_i),
        .dev_opmode_i(dev_opmode_i)
`ifdef MBUF_FILL_LEVEL_EN
        , .fill_level_o(fill)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // A request is accepted only when nothing is presented to the device and no drain is due
    function automatic bit m_ready();
        if (reset || pres_v) return 0;
        if (half_v) return 1;
        if (dev_opmode_i && mq.size() > 0) return 0;
        return !(MASK[req_tid_i] && mq.size() == DEPTH);
    endfunction

    initial forever begin
        @(posedge clk);
        if (reset) begin
            armed = 1;
            mq.delete();
            half_v = 0;
            pres_v = 0;
        end else if (armed) begin
            if (pres_v) begin
                if (dev_ready_i) pres_v = 0;
            end else if (!half_v && dev_opmode_i && mq.size() > 0) begin
                {pres_addr, pres_data} = mq.pop_front();
                pres_v = 1;
            end else if (req_tvalid_i && m_ready()) begin
                if (!half_v) begin
                    half_v = 1;
                    half_a = req_tdata_i;
                    half_id = req_tid_i;
                end else begin
                    half_v = 0;
                    if (MASK[half_id]) mq.push_back({half_a, half_id, req_tdata_i});
                    else begin
                        pres_v = 1;
                        pres_addr = {half_a, half_id};
                        pres_data = req_tdata_i;
                    end
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (armed) begin
            chk("tready", req_tready_o, m_ready());
            chk("dev_valid", dev_valid_o, pres_v);
            chk("dev_addr", dev_addr_o, pres_v ? pres_addr : 19'd0);
            chk("dev_data", dev_data_o, pres_v ? pres_data : 16'd0);
`ifdef MBUF_FILL_LEVEL_EN
            chk("fill_level", fill, mq.size());
`endif
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [2:0] tid, input logic [15:0] d);
        bit ok = 0;
        int n = 0;
        req_tvalid_i = 1;
        req_tid_i = tid;
        req_tdata_i = d;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = req_tready_o;
            @(posedge clk);
            #1;
            n++;
        end
        req_tvalid_i = 0;
        chk("beat_accept", ok, 1);
    endtask

    task automatic send(input logic [2:0] tid, input logic [15:0] a, input logic [15:0] d);
        beat(tid, a);
        beat(3'($urandom_range(0, 7)), d);
    endtask

    task automatic wait_dev(input string nm, input logic [18:0] a, input logic [15:0] d);
        int n = 0;
        @(negedge clk);
        while (!dev_valid_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_valid"}, dev_valid_o, 1);
        chk({nm, "_addr"}, dev_addr_o, a);
        chk({nm, "_data"}, dev_data_o, d);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1;
        req_tvalid_i = 0;
        req_tid_i = 0;
        req_tdata_i = 0;
        dev_ready_i = 1;
        dev_opmode_i = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 0;
        @(negedge clk);
        chk("rst_valid", dev_valid_o, 0);
        chk("rst_tready", req_tready_o, 1);
        cycles(1);
        // pass-through, valid the cycle right after beat 1
        send(3'd2, 16'h1234, 16'hBEEF);
        @(negedge clk);
        chk("pt_valid", dev_valid_o, 1);
        chk("pt_addr", dev_addr_o, 19'h091A2);
        chk("pt_data", dev_data_o, 16'hBEEF);
        cycles(2);
        // buffer two, then drain in order
        send(3'd5, 16'h0010, 16'hAAAA);
        send(3'd5, 16'h0020, 16'hBBBB);
        cycles(3);
        @(negedge clk);
        chk("buf_no_valid", dev_valid_o, 0);
`ifdef MBUF_FILL_LEVEL_EN
        chk("buf_fill2", fill, 2);
`endif
        cycles(1);
        dev_opmode_i = 1;
        wait_dev("drain0", 19'h00085, 16'hAAAA);
        wait_dev("drain1", 19'h00105, 16'hBBBB);
        dev_opmode_i = 0;
        cycles(2);
        // fill to the brim, buffered ID stalls, pass-through still flows
        for (int i = 0; i < 8; i++) send(3'd5, 16'(i), 16'(i * 3));
        req_tvalid_i = 1;
        req_tid_i = 3'd5;
        req_tdata_i = 16'h0100;
        repeat (3) begin
            @(negedge clk);
            chk("full_stall", req_tready_o, 0);
            @(posedge clk);
            #1;
        end
        req_tvalid_i = 0;
        send(3'd1, 16'h0777, 16'h4242);
        wait_dev("full_pt", 19'h03BB9, 16'h4242);
        dev_opmode_i = 1;
        cycles(25);
        dev_opmode_i = 0;
        // device back-pressure holds the presented request
        dev_ready_i = 0;
        send(3'd2, 16'h0ABC, 16'h1357);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", dev_valid_o, 1);
            chk("bp_addr", dev_addr_o, 19'h055E2);
            chk("bp_data", dev_data_o, 16'h1357);
            chk("bp_tready", req_tready_o, 0);
            @(posedge clk);
            #1;
        end
        dev_ready_i = 1;
        @(negedge clk);
        chk("bp_accept", dev_valid_o, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_done", dev_valid_o, 0);
        cycles(1);
        // drain priority over a waiting address beat
        send(3'd5, 16'h0030, 16'hCCCC);
        dev_opmode_i = 1;
        req_tvalid_i = 1;
        req_tid_i = 3'd0;
        req_tdata_i = 16'h0040;
        @(negedge clk);
        chk("prio_tready", req_tready_o, 0);
        cycles(1);
        @(negedge clk);
        chk("prio_drain_valid", dev_valid_o, 1);
        chk("prio_drain_addr", dev_addr_o, 19'h00185);
        cycles(1);
        @(negedge clk);
        chk("prio_tready_after", req_tready_o, 1);
        cycles(1);
        req_tdata_i = 16'hDDDD;
        cycles(1);
        req_tvalid_i = 0;
        @(negedge clk);
        chk("prio_req_addr", dev_addr_o, 19'h00200);
        chk("prio_req_data", dev_data_o, 16'hDDDD);
        cycles(1);
        dev_opmode_i = 0;
        // reset mid-request with entries buffered
        for (int i = 0; i < 3; i++) send(3'd5, 16'(16'h0050 + i), 16'(i));
        beat(3'd5, 16'h0099);
        reset = 1;
        cycles(1);
        reset = 0;
        @(negedge clk);
        chk("rst2_valid", dev_valid_o, 0);
        chk("rst2_tready", req_tready_o, 1);
`ifdef MBUF_FILL_LEVEL_EN
        chk("rst2_fill", fill, 0);
`endif
        dev_opmode_i = 1;
        repeat (5) begin
            @(negedge clk);
            chk("rst2_no_drain", dev_valid_o, 0);
            @(posedge clk);
            #1;
        end
        // randomized traffic against the model
        rnd = 1;
        fork
            while (rnd) begin
                @(posedge clk);
                #1;
                dev_ready_i = 1'($urandom_range(0, 1));
                dev_opmode_i = $urandom_range(0, 3) != 0;
            end
        join_none
        for (int i = 0; i < 200; i++) begin
            cycles($urandom_range(0, 2));
            send($urandom_range(0, 1) ? 3'd5 : 3'($urandom_range(0, 7)),
                 16'($urandom), 16'($urandom));
        end
        rnd = 0;
        cycles(2);
        dev_ready_i = 1;
        dev_opmode_i = 1;
        cycles(40);
        @(negedge clk);
        chk("final_idle", dev_valid_o, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/multi_id_buffering.md
# multi_id_buffering

Parametrised successor of the single-ID request buffer. It accepts two-beat AXI Stream write requests (address beat, then data beat) and forwards them on a valid-ready device port. Requests whose ID is selected by a mask are parked in an internal FIFO and drained only while the device reports operational mode. It sits between the request fabric and the device, and adds a configurable data width, ID width, FIFO depth, a buffered-ID mask, and full-aware per-ID back-pressure.

## Interface
- DATA_W, 16, width of address and data beats
- ID_W, 3, width of transaction ID
- DEPTH, 8, FIFO entries; power of two, ≥2
- BUF_ID_MASK, 8'b0010_0000, width 2**ID_W; bit n=1 means ID n is buffered
- clk  in  1  clock
- reset  in  1  reset; one clock, reset is synchronous and active-high
- req_tvalid_i  in  1  request beat valid
- req_tid_i  in  ID_W  request ID (sampled on address beat)
- req_tdata_i  in  DATA_W  address (beat 0) or data (beat 1)
- req_tready_o  out  1  request beat accepted
- dev_valid_o  out  1  device request valid
- dev_addr_o  out  DATA_W+ID_W  {address, id}
- dev_data_o  out  DATA_W  write data
- dev_ready_i  in  1  device accepts
- dev_opmode_i  in  1  device in operational mode; drain permitted
- fill_level_o  out  $clog2(DEPTH+1)  FIFO occupancy (only with MBUF_FILL_LEVEL_EN)

## Operation
- A beat transfers when req_tvalid_i && req_tready_o. Each request is two beats: beat 0 carries the address and ID, beat 1 carries the data. req_tid_i on beat 1 is ignored.
- FSM states: IDLE, DATA, SEND, DRAIN. Reset state is IDLE.
- IDLE:
  - If dev_opmode_i && !empty: req_tready_o=0, pop the FIFO head into the output registers, next state DRAIN. Drain has priority over new requests.
  - Else req_tready_o=1, except when the ID is buffered (BUF_ID_MASK[req_tid_i]=1) and the FIFO is full; then req_tready_o=0.
  - On beat 0 transfer: capture {tdata, tid}, next state DATA.
- DATA:
  - req_tready_o=1. On transfer, capture the data.
  - Buffered ID: push {addr, id, data} into the FIFO, next state IDLE.
  - Otherwise: next state SEND.
- SEND: dev_valid_o=1 with the captured addr/data. When dev_ready_i=1, next state IDLE. req_tready_o=0.
- DRAIN: dev_valid_o=1 with the popped entry. When dev_ready_i=1, next state IDLE. req_tready_o=0.
- dev_addr_o and dev_data_o are 0 whenever dev_valid_o=0.
- The FIFO is circular, with wrap-around pointers and a separate count. Push and pop never occur in the same cycle.
- Pass-through requests are never blocked by a full FIFO or by opmode=0.
- Drain order is FIFO order, across all buffered IDs.

## Timing
- Reset values: req_tready_o=0 during reset, dev_valid_o=0, dev_addr_o=0, dev_data_o=0, fill_level_o=0, FIFO empty.
- req_tready_o is combinational from state, tid, full, empty, and opmode.
- Pass-through latency: dev_valid_o rises in the cycle after the beat-1 transfer. The minimum request-to-request interval is 3 cycles with dev_ready_i held at 1.
- Buffered push: the count increments in the cycle after the beat-1 transfer.
- Drain: dev_valid_o rises in the cycle after IDLE sees opmode && !empty. The count decrements at the same edge.
- The device handshake holds dev_valid, dev_addr, and dev_data stable until dev_ready_i.
- opmode falling during DRAIN does not withdraw the presented entry. Only the next pop is inhibited.
- Synchronous reset at any point discards a partial request, a pending SEND, and all FIFO contents.

## Configuration
- MBUF_FILL_LEVEL_EN defined: the fill_level_o port exists and equals the current FIFO count, registered.
- MBUF_FILL_LEVEL_EN undefined: the port is absent; behaviour is otherwise identical.

## Test plan
- Pass-through: tid=2, addr=0x1234, data=0xBEEF, dev_ready=1 → one beat with dev_addr_o=0x91A2 ({0x1234,3'd2}) and dev_data_o=0xBEEF, one cycle after beat 1.
- Buffer and drain: opmode=0, tid=5 requests (0x0010,0xAAAA) and (0x0020,0xBBBB) → no dev_valid, fill level 2. Then raise opmode → device sees 0x0085/0xAAAA, then 0x0105/0xBBBB, fill level 0.
- Full stall: opmode=0, 8 tid=5 requests → fill level 8. A 9th tid=5 beat 0 sees tready=0. A tid=1 request is still forwarded.
- Back-pressure: dev_ready=0 for 5 cycles in SEND → dev_valid/addr/data stable, tready=0. Accepted on the cycle dev_ready=1.
- Priority: FIFO non-empty, opmode=1, tid=0 beat 0 valid in IDLE → tready=0, drain occurs first, then the tid=0 request is accepted.
- Reset: assert reset during DATA with 3 entries buffered → next cycle IDLE, fill level 0, dev_valid_o=0, no stale drain after opmode=1.
